stack_frame_sequencer: RTL and testbench

- Initiator FSM that drives the memory stage's stack port for CALL, INT, RET and RTI.
- Expands each request into a fixed multi-cycle sequence of push or pop cycles, stalling the front end meanwhile.
- For returns, reassembles the 32-bit return PC and the 3-bit flags from the popped 16-bit words, then issues the PC redirect.
- Sits between decode/execute control and the memory stage.

---
 rtl/stack_frame_sequencer_pkg.sv | 22 ++
 rtl/stack_frame_sequencer_occupancy.sv | 51 +++++
 rtl/stack_frame_sequencer.sv | 173 +++++++++++++++++
 tb/tb_stack_frame_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_frame_sequencer_pkg.sv
// Shared types and encodings for the stack frame sequencer and its occupancy counter.
package stack_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PUSH_FLAGS = 3'd1,
        ST_PUSH_HI    = 3'd2,
        ST_PUSH_LO    = 3'd3,
        ST_POP_LO     = 3'd4,
        ST_POP_HI     = 3'd5,
        ST_POP_FLAGS  = 3'd6,
        ST_REDIRECT   = 3'd7
    } state_e;

    localparam logic [1:0] WSRC_FLAGS = 2'b00;
    localparam logic [1:0] WSRC_PC_HI = 2'b01;
    localparam logic [1:0] WSRC_PC_LO = 2'b10;

    localparam logic [1:0] ADDR_SP    = 2'b10;
    localparam logic [1:0] ADDR_NONE  = 2'b00;

endpackage

// File: rtl/stack_frame_sequencer_occupancy.sv
// Stack occupancy tracker: counts pushed words and flags requests that would over/underflow.
module stack_occupancy_counter
    import stack_frame_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = 1024,
    parameter int CNT_W       = 11
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic chk_call_i,
    input  logic chk_int_i,
    input  logic chk_ret_i,
    input  logic chk_rti_i,
    output logic fault_now_o,
    output logic stack_fault_o
);

    localparam logic [CNT_W-1:0] CALL_MAX = CNT_W'(STACK_DEPTH - 2);
    localparam logic [CNT_W-1:0] INT_MAX  = CNT_W'(STACK_DEPTH - 3);
    localparam logic [CNT_W-1:0] RET_MIN  = CNT_W'(2);
    localparam logic [CNT_W-1:0] RTI_MIN  = CNT_W'(3);

    logic [CNT_W-1:0] count_q;
    logic             fault_q;

    assign fault_now_o = (chk_call_i && (count_q > CALL_MAX))
                       || (chk_int_i  && (count_q > INT_MAX))
                       || (chk_ret_i  && (count_q < RET_MIN))
                       || (chk_rti_i  && (count_q < RTI_MIN));

    assign stack_fault_o = fault_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (inc_i && !dec_i) begin
                count_q <= count_q + 1'b1;
            end else if (dec_i && !inc_i) begin
                count_q <= count_q - 1'b1;
            end
            if (fault_now_o) begin
                fault_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stack_frame_sequencer.sv
// Expands CALL/INT/RET/RTI into stack push/pop cycles and reassembles the return PC and flags.
module stack_frame_sequencer
    import stack_frame_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = 1024,
    parameter int CNT_W       = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_call,
    input  logic        req_int,
    input  logic        req_ret,
    input  logic        req_rti,
    input  logic [15:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_push,
    output logic        mem_pop,
    output logic [1:0]  mem_addr_sel,
    output logic [1:0]  mem_wsrc_sel,
    output logic        pc_choose_memory,
    output logic        interrupt,
    output logic [31:0] return_pc,
    output logic [2:0]  flags_out,
    output logic        flags_restore,
    output logic        stall,
    output logic        stack_fault,
    output logic        done
);

    state_e state_q, state_d;
    logic   pending_int_q, pending_int_d;
    logic   is_int_q, is_int_d;
    logic   is_rti_q, is_rti_d;
    logic   chk_call, chk_int, chk_ret, chk_rti;
    logic   fault_now;

    stack_occupancy_counter #(
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_W       (CNT_W)
    ) u_occupancy (
        .clk_i         (clk),
        .reset_i       (reset),
        .inc_i         (mem_push),
        .dec_i         (mem_pop),
        .chk_call_i    (chk_call),
        .chk_int_i     (chk_int),
        .chk_ret_i     (chk_ret),
        .chk_rti_i     (chk_rti),
        .fault_now_o   (fault_now),
        .stack_fault_o (stack_fault)
    );

    always_comb begin
        state_d          = state_q;
        pending_int_d    = pending_int_q;
        is_int_d         = is_int_q;
        is_rti_d         = is_rti_q;
        chk_call         = 1'b0;
        chk_int          = 1'b0;
        chk_ret          = 1'b0;
        chk_rti          = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_push         = 1'b0;
        mem_pop          = 1'b0;
        mem_addr_sel     = ADDR_NONE;
        mem_wsrc_sel     = WSRC_FLAGS;
        pc_choose_memory = 1'b0;
        interrupt        = 1'b0;
        flags_restore    = 1'b0;
        stall            = 1'b0;
        done             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!reset) begin
                    // A deferred interrupt outranks anything arriving in this cycle.
                    if (pending_int_q || req_int) begin
                        chk_int = 1'b1;
                    end else if (req_rti) begin
                        chk_rti = 1'b1;
                    end else if (req_ret) begin
                        chk_ret = 1'b1;
                    end else if (req_call) begin
                        chk_call = 1'b1;
                    end
                    pending_int_d = 1'b0;
                    if ((chk_int || chk_rti || chk_ret || chk_call) && !fault_now) begin
                        stall    = 1'b1;
                        is_int_d = chk_int;
                        is_rti_d = chk_rti;
                        if (chk_int) begin
                            state_d = ST_PUSH_FLAGS;
                        end else if (chk_call) begin
                            state_d = ST_PUSH_HI;
                        end else begin
                            state_d = ST_POP_LO;
                        end
                    end
                end
            end
            ST_PUSH_FLAGS, ST_PUSH_HI, ST_PUSH_LO: begin
                stall        = 1'b1;
                mem_write    = 1'b1;
                mem_push     = 1'b1;
                mem_addr_sel = ADDR_SP;
                if (state_q == ST_PUSH_FLAGS) begin
                    mem_wsrc_sel = WSRC_FLAGS;
                    state_d      = ST_PUSH_HI;
                end else if (state_q == ST_PUSH_HI) begin
                    mem_wsrc_sel = WSRC_PC_HI;
                    state_d      = ST_PUSH_LO;
                end else begin
                    mem_wsrc_sel = WSRC_PC_LO;
                    done         = 1'b1;
                    interrupt    = is_int_q;
                    state_d      = ST_IDLE;
                end
            end
            ST_POP_LO, ST_POP_HI, ST_POP_FLAGS: begin
                stall        = 1'b1;
                mem_read     = 1'b1;
                mem_pop      = 1'b1;
                mem_addr_sel = ADDR_SP;
                if (state_q == ST_POP_LO) begin
                    state_d = ST_POP_HI;
                end else if (state_q == ST_POP_HI && is_rti_q) begin
                    state_d = ST_POP_FLAGS;
                end else begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                stall            = 1'b1;
                pc_choose_memory = 1'b1;
                done             = 1'b1;
                flags_restore    = is_rti_q;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && req_int) begin
            pending_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pending_int_q <= 1'b0;
            is_int_q      <= 1'b0;
            is_rti_q      <= 1'b0;
            return_pc     <= '0;
            flags_out     <= '0;
        end else begin
            state_q       <= state_d;
            pending_int_q <= pending_int_d;
            is_int_q      <= is_int_d;
            is_rti_q      <= is_rti_d;
            case (state_q)
                ST_POP_LO:    return_pc[15:0]  <= mem_data_in;
                ST_POP_HI:    return_pc[31:16] <= mem_data_in;
                ST_POP_FLAGS: flags_out        <= mem_data_in[2:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_frame_sequencer.sv
// Scoreboard bench for stack_frame_sequencer: a stack-level model predicts every bus cycle and redirect.
module tb_stack_frame_sequencer;

    localparam int OP_CALL = 0;
    localparam int OP_INT  = 1;
    localparam int OP_RET  = 2;
    localparam int OP_RTI  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_call, req_int, req_ret, req_rti;
    logic [15:0] mem_data_in;
    logic        mem_read, mem_write, mem_push, mem_pop;
    logic [1:0]  mem_addr_sel, mem_wsrc_sel;
    logic        pc_choose_memory, interrupt;
    logic [31:0] return_pc;
    logic [2:0]  flags_out;
    logic        flags_restore, stall, stack_fault, done;

    always #5 clk = ~clk;

    stack_frame_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .req_call         (req_call),
        .req_int          (req_int),
        .req_ret          (req_ret),
        .req_rti          (req_rti),
        .mem_data_in      (mem_data_in),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_push         (mem_push),
        .mem_pop          (mem_pop),
        .mem_addr_sel     (mem_addr_sel),
        .mem_wsrc_sel     (mem_wsrc_sel),
        .pc_choose_memory (pc_choose_memory),
        .interrupt        (interrupt),
        .return_pc        (return_pc),
        .flags_out        (flags_out),
        .flags_restore    (flags_restore),
        .stall            (stall),
        .stack_fault      (stack_fault),
        .done             (done)
    );

    // Data memory and SP: the environment the sequencer drives.
    logic [31:0] cur_pc;
    logic [2:0]  cur_flags;
    logic [15:0] tb_mem [0:1023];
    logic [10:0] sp_q;
    logic [9:0]  rd_idx;
    logic [15:0] wdata;

    assign rd_idx      = sp_q[9:0] - 10'd1;
    assign mem_data_in = tb_mem[rd_idx];

    always_comb begin
        case (mem_wsrc_sel)
            2'b00:   wdata = {13'b0, cur_flags};
            2'b01:   wdata = cur_pc[31:16];
            2'b10:   wdata = cur_pc[15:0];
            default: wdata = 16'hdead;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else if (mem_write && mem_push) begin
            tb_mem[sp_q[9:0]] <= wdata;
            sp_q <= sp_q + 11'd1;
        end else if (mem_read && mem_pop) begin
            sp_q <= sp_q - 11'd1;
        end
    end

    // Reference model and scoreboard queues.
    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       push;
        logic       pop;
        logic [1:0] addr;
        logic [1:0] wsrc;
        logic       done;
        logic       intr;
        logic       pcsel;
        logic       frest;
    } rec_t;

    rec_t        exp_q[$];
    logic [31:0] rpc_q[$];
    logic [2:0]  flg_q[$];
    logic [15:0] model_stack[$];
    logic [2:0]  model_flags;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic rec_t mk(logic wr, logic rd, logic [1:0] wsrc,
                                logic dn, logic intr, logic pcsel, logic frest);
        rec_t r;
        r.wr    = wr;
        r.rd    = rd;
        r.push  = wr;
        r.pop   = rd;
        r.addr  = (wr || rd) ? 2'b10 : 2'b00;
        r.wsrc  = wsrc;
        r.done  = dn;
        r.intr  = intr;
        r.pcsel = pcsel;
        r.frest = frest;
        return r;
    endfunction

    function automatic int seq_len(int op);
        case (op)
            OP_CALL: return 2;
            OP_INT:  return 3;
            OP_RET:  return 3;
            default: return 4;
        endcase
    endfunction

    task automatic model_op(int op);
        logic [15:0] lo, hi, fw;
        case (op)
            OP_CALL: begin
                model_stack.push_back(cur_pc[31:16]);
                model_stack.push_back(cur_pc[15:0]);
                exp_q.push_back(mk(1, 0, 2'b01, 0, 0, 0, 0));
                exp_q.push_back(mk(1, 0, 2'b10, 1, 0, 0, 0));
            end
            OP_INT: begin
                model_stack.push_back({13'b0, cur_flags});
                model_stack.push_back(cur_pc[31:16]);
                model_stack.push_back(cur_pc[15:0]);
                exp_q.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0));
                exp_q.push_back(mk(1, 0, 2'b01, 0, 0, 0, 0));
                exp_q.push_back(mk(1, 0, 2'b10, 1, 1, 0, 0));
            end
            OP_RET: begin
                lo = model_stack.pop_back();
                hi = model_stack.pop_back();
                exp_q.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 0, 2'b00, 1, 0, 1, 0));
                rpc_q.push_back({hi, lo});
                flg_q.push_back(model_flags);
            end
            default: begin
                lo = model_stack.pop_back();
                hi = model_stack.pop_back();
                fw = model_stack.pop_back();
                model_flags = fw[2:0];
                exp_q.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 0, 2'b00, 1, 0, 1, 1));
                rpc_q.push_back({hi, lo});
                flg_q.push_back(model_flags);
            end
        endcase
    endtask

    // Monitor: every cycle with bus/redirect activity must match the next predicted cycle.
    always @(negedge clk) begin
        rec_t o, e;
        if (mem_write === 1'b1 || mem_read === 1'b1 || mem_push === 1'b1 || mem_pop === 1'b1 ||
            pc_choose_memory === 1'b1 || done === 1'b1 || interrupt === 1'b1 || flags_restore === 1'b1) begin
            o.wr    = mem_write;
            o.rd    = mem_read;
            o.push  = mem_push;
            o.pop   = mem_pop;
            o.addr  = mem_addr_sel;
            o.wsrc  = mem_wsrc_sel;
            o.done  = done;
            o.intr  = interrupt;
            o.pcsel = pc_choose_memory;
            o.frest = flags_restore;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_cycle: got %0h expected no activity", o);
            end else begin
                e = exp_q.pop_front();
                chk("cycle_rec", 64'(o), 64'(e));
            end
            if (pc_choose_memory === 1'b1) begin
                if (rpc_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_redirect: got %0h expected none", return_pc);
                end else begin
                    chk("return_pc", 64'(return_pc), 64'(rpc_q.pop_front()));
                    chk("flags_out", 64'(flags_out), 64'(flg_q.pop_front()));
                end
            end
        end
    end

    // Stimulus: tasks start and end at posedge+1.
    task automatic set_reqs(logic [3:0] v);
        {req_rti, req_ret, req_int, req_call} = v;
    endtask

    task automatic issue(int op, logic [3:0] extra);
        logic [3:0] v;
        v     = extra;
        v[op] = 1'b1;
        model_op(op);
        set_reqs(v);
        @(negedge clk);
        chk("stall_accept", 64'(stall), 64'd1);
        @(posedge clk); #1;
        set_reqs(4'b0);
        repeat (seq_len(op)) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_reqs(4'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        rpc_q.delete();
        flg_q.delete();
        model_stack.delete();
        model_flags = 3'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({mem_read, mem_write, mem_push, mem_pop, mem_addr_sel, mem_wsrc_sel,
                    pc_choose_memory, interrupt, return_pc, flags_out, flags_restore,
                    stall, stack_fault, done});
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] extra;
        int op, occ;
        reset       = 1'b1;
        cur_pc      = '0;
        cur_flags   = '0;
        model_flags = '0;
        set_reqs(4'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        @(posedge clk); #1;

        // CALL then RET round trip.
        cur_pc = 32'h0001_2345;
        issue(OP_CALL, 4'b0);
        issue(OP_RET, 4'b0);
        chk("ret_pc_value", 64'(return_pc), 64'h0001_2345);

        // INT then RTI restoring flags.
        cur_pc    = 32'h0000_0040;
        cur_flags = 3'b101;
        issue(OP_INT, 4'b0);
        issue(OP_RTI, 4'b0);
        chk("rti_pc_value", 64'(return_pc), 64'h0000_0040);
        chk("rti_flags_value", 64'(flags_out), 64'd5);

        // Interrupt arriving mid-RET is deferred by exactly one IDLE cycle.
        cur_pc = $urandom;
        issue(OP_CALL, 4'b0);
        model_op(OP_RET);
        set_reqs(4'b0100);
        @(posedge clk); #1;
        set_reqs(4'b0);
        @(posedge clk); #1;
        cur_pc    = $urandom;
        cur_flags = 3'($urandom_range(0, 7));
        model_op(OP_INT);
        req_int = 1'b1;
        @(posedge clk); #1;
        req_int = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pend_gap_write", 64'(mem_write), 64'd0);
        chk("pend_gap_stall", 64'(stall), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pend_start_write", 64'(mem_write), 64'd1);
        chk("pend_start_wsrc", 64'(mem_wsrc_sel), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Simultaneous CALL and INT: INT wins, CALL dropped.
        cur_pc = $urandom;
        issue(OP_INT, 4'b0001);

        // Randomized legal traffic with lower-priority requests mixed in.
        for (int i = 0; i < 40; i++) begin
            occ = model_stack.size();
            op  = $urandom_range(0, 3);
            if (occ > 40) op = OP_RET;
            if (op == OP_RET && occ < 2) op = OP_CALL;
            if (op == OP_RTI && occ < 3) op = OP_INT;
            cur_pc    = $urandom;
            cur_flags = 3'($urandom_range(0, 7));
            case (op)
                OP_INT:  extra = 4'($urandom_range(0, 15)) & 4'b1101;
                OP_RTI:  extra = 4'($urandom_range(0, 15)) & 4'b0101;
                OP_RET:  extra = 4'($urandom_range(0, 15)) & 4'b0001;
                default: extra = 4'b0;
            endcase
            issue(op, extra);
        end
        chk("no_fault_legal", 64'(stack_fault), 64'd0);

        // Underflow: RET on an empty stack.
        do_reset();
        req_ret = 1'b1;
        @(negedge clk);
        chk("udf_no_read_now", 64'(mem_read), 64'd0);
        @(posedge clk); #1;
        req_ret = 1'b0;
        @(negedge clk);
        chk("udf_fault", 64'(stack_fault), 64'd1);
        chk("udf_no_read", 64'(mem_read), 64'd0);
        @(posedge clk); #1;

        // Overflow: fill to 1023 words, then CALL.
        do_reset();
        cur_pc = $urandom;
        issue(OP_INT, 4'b0);
        for (int i = 0; i < 510; i++) begin
            cur_pc = $urandom;
            issue(OP_CALL, 4'b0);
        end
        chk("fill_no_fault", 64'(stack_fault), 64'd0);
        chk("fill_level", 64'(model_stack.size()), 64'd1023);
        req_call = 1'b1;
        @(posedge clk); #1;
        req_call = 1'b0;
        @(negedge clk);
        chk("ovf_fault", 64'(stack_fault), 64'd1);
        chk("ovf_no_write", 64'(mem_write), 64'd0);
        @(posedge clk); #1;

        // Reset during POP_HI aborts the RET.
        do_reset();
        cur_pc = $urandom;
        issue(OP_CALL, 4'b0);
        model_op(OP_RET);
        set_reqs(4'b0100);
        @(posedge clk); #1;
        set_reqs(4'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        rpc_q.delete();
        flg_q.delete();
        model_stack.delete();
        @(negedge clk);
        chk("abort_outputs", all_outs(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
